// File: rtl/tx_encoder_8b10b.sv
// 8b/10b transmit encoder: one byte per BitCLK_10 to one registered 10-bit code group,
// tracking running disparity and inserting K28.5 idles when no data is presented.
module tx_encoder_8b10b (
   input  logic       BitCLK_10,
   input  logic       Reset,
   input  logic       TxValid,
   input  logic [7:0] TxParallel_8,
   input  logic       TxDataK,
   output logic [9:0] TxParallel_10,
   output logic       RunDisp,
   output logic       TxCodeError,
   output logic       TxIdle
);

   // 5b/6b data table, RD- column, written abcdei with a in the MSB
   function automatic logic [5:0] enc6_neg(input logic [4:0] x);
      case (x)
         5'd0:  enc6_neg = 6'b100111;
         5'd1:  enc6_neg = 6'b011101;
         5'd2:  enc6_neg = 6'b101101;
         5'd3:  enc6_neg = 6'b110001;
         5'd4:  enc6_neg = 6'b110101;
         5'd5:  enc6_neg = 6'b101001;
         5'd6:  enc6_neg = 6'b011001;
         5'd7:  enc6_neg = 6'b111000;
         5'd8:  enc6_neg = 6'b111001;
         5'd9:  enc6_neg = 6'b100101;
         5'd10: enc6_neg = 6'b010101;
         5'd11: enc6_neg = 6'b110100;
         5'd12: enc6_neg = 6'b001101;
         5'd13: enc6_neg = 6'b101100;
         5'd14: enc6_neg = 6'b011100;
         5'd15: enc6_neg = 6'b010111;
         5'd16: enc6_neg = 6'b011011;
         5'd17: enc6_neg = 6'b100011;
         5'd18: enc6_neg = 6'b010011;
         5'd19: enc6_neg = 6'b110010;
         5'd20: enc6_neg = 6'b001011;
         5'd21: enc6_neg = 6'b101010;
         5'd22: enc6_neg = 6'b011010;
         5'd23: enc6_neg = 6'b111010;
         5'd24: enc6_neg = 6'b110011;
         5'd25: enc6_neg = 6'b100110;
         5'd26: enc6_neg = 6'b010110;
         5'd27: enc6_neg = 6'b110110;
         5'd28: enc6_neg = 6'b001110;
         5'd29: enc6_neg = 6'b101110;
         5'd30: enc6_neg = 6'b011110;
         default: enc6_neg = 6'b101011;
      endcase
   endfunction

   // 3b/4b data table, RD- column (P7 for y=7), written fghj with f in the MSB
   function automatic logic [3:0] enc4_neg(input logic [2:0] y);
      case (y)
         3'd0: enc4_neg = 4'b1011;
         3'd1: enc4_neg = 4'b1001;
         3'd2: enc4_neg = 4'b0101;
         3'd3: enc4_neg = 4'b1100;
         3'd4: enc4_neg = 4'b1101;
         3'd5: enc4_neg = 4'b1010;
         3'd6: enc4_neg = 4'b0110;
         default: enc4_neg = 4'b1110;
      endcase
   endfunction

   logic [7:0] w_byte;
   logic       w_k;
   logic [4:0] w_x;
   logic [2:0] w_y;
   logic       w_k28;
   logic       w_kx7;
   logic       w_legal_k;
   logic       w_err;
   logic [5:0] w_6n;
   logic [5:0] w_6;
   logic       w_6_unbal;
   logic       w_rd6;
   logic       w_alt7;
   logic [3:0] w_4n;
   logic [3:0] w_4;
   logic       w_4_unbal;
   logic       w_rd4;
   logic [9:0] w_code;

   logic [9:0] r_code;
   logic       r_rd;
   logic       r_err;
   logic       r_idle;

   always_comb begin
      w_byte    = TxValid ? TxParallel_8 : 8'hBC;
      w_k       = TxValid ? TxDataK : 1'b1;
      w_x       = w_byte[4:0];
      w_y       = w_byte[7:5];
      w_k28     = w_k && (w_x == 5'd28);
      w_kx7     = w_k && (w_y == 3'd7) &&
                  ((w_x == 5'd23) || (w_x == 5'd27) || (w_x == 5'd29) || (w_x == 5'd30));
      w_legal_k = w_k28 || w_kx7;
      w_err     = TxValid && TxDataK && !w_legal_k;

      // 6b sub-block chosen by the current RD; D.7 is the one neutral form that flips
      w_6n      = w_k28 ? 6'b001111 : enc6_neg(w_x);
      w_6_unbal = ($countones(w_6n) != 3);
      w_6       = (r_rd && (w_6_unbal || (w_x == 5'd7))) ? ~w_6n : w_6n;
      w_rd6     = w_6_unbal ? ~r_rd : r_rd;

      // 4b sub-block chosen by the RD left behind by the 6b sub-block
      w_alt7    = (w_y == 3'd7) &&
                  (w_legal_k ||
                   (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                   ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));
      w_4n      = w_alt7 ? 4'b0111 : enc4_neg(w_y);
      w_4_unbal = ($countones(w_4n) != 2);
      w_4       = w_4n;
      if (w_4_unbal || (w_y == 3'd3)) begin
         if (w_rd6) w_4 = ~w_4n;
      end else if (w_k28 && !w_rd6) begin
         // K28.1/.2/.5/.6 use the complement of the data form behind an RD- 6b block
         w_4 = ~w_4n;
      end
      w_rd4     = w_4_unbal ? ~w_rd6 : w_rd6;

      w_code    = {w_4[0], w_4[1], w_4[2], w_4[3],
                   w_6[0], w_6[1], w_6[2], w_6[3], w_6[4], w_6[5]};
   end

   always_ff @(posedge BitCLK_10) begin
      if (Reset) begin
         r_code <= 10'h17C;
         r_rd   <= 1'b1;
         r_err  <= 1'b0;
         r_idle <= 1'b0;
      end else begin
         r_code <= w_code;
         r_rd   <= w_rd4;
         r_err  <= w_err;
         r_idle <= !TxValid;
      end
   end

   assign TxParallel_10 = r_code;
   assign RunDisp       = r_rd;
   assign TxCodeError   = r_err;
   assign TxIdle        = r_idle;

endmodule

// File: tb/tb_tx_encoder_8b10b.sv
// Bench for tx_encoder_8b10b: table-driven reference encoder feeds a scoreboard queue,
// a monitor pops one expectation per output word and also tracks cumulative disparity.
module tb_tx_encoder_8b10b;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       TxValid = 1'b0;
   logic [7:0] TxParallel_8 = 8'h00;
   logic       TxDataK = 1'b0;
   logic [9:0] TxParallel_10;
   logic       RunDisp;
   logic       TxCodeError;
   logic       TxIdle;

   tx_encoder_8b10b dut (
      .BitCLK_10    (clk),
      .Reset        (Reset),
      .TxValid      (TxValid),
      .TxParallel_8 (TxParallel_8),
      .TxDataK      (TxDataK),
      .TxParallel_10(TxParallel_10),
      .RunDisp      (RunDisp),
      .TxCodeError  (TxCodeError),
      .TxIdle       (TxIdle)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] code;
      logic       rd;
      logic       err;
      logic       idle;
      logic       rst;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic m_rd = 1'b1;

   // Standard tables with both disparity columns written out (MSB = a / f)
   localparam logic [5:0] T6N [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [5:0] T6P [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                      4'b1101, 4'b1010, 4'b0110, 4'b1110};
   localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                      4'b0010, 4'b1010, 4'b0110, 4'b0001};
   // K28.y 4b forms indexed by the RD at the start of the whole code group
   localparam logic [3:0] K4N [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                      4'b0010, 4'b1010, 4'b0110, 4'b1000};
   localparam logic [3:0] K4P [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                      4'b1101, 4'b0101, 4'b1001, 4'b0111};
   localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                           8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

   function automatic logic blk_rd(input logic rd, input int ones, input int half);
      if (ones > half) return 1'b1;
      if (ones < half) return 1'b0;
      return rd;
   endfunction

   task automatic model_enc(input logic v, input logic [7:0] b_in, input logic k_in,
                            output exp_t e);
      logic [7:0] b;
      logic       k;
      logic [4:0] x;
      logic [2:0] y;
      logic       legal;
      logic       a7;
      logic [5:0] s6;
      logic [3:0] s4;
      logic       rd6;
      b = v ? b_in : 8'hBC;
      k = v ? k_in : 1'b1;
      x = b[4:0];
      y = b[7:5];
      legal = k && ((x == 5'd28) ||
                    ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
      if (legal && (x == 5'd28)) begin
         s6  = m_rd ? 6'b110000 : 6'b001111;
         s4  = m_rd ? K4P[y] : K4N[y];
         rd6 = blk_rd(m_rd, $countones(s6), 3);
      end else begin
         s6  = m_rd ? T6P[x] : T6N[x];
         rd6 = blk_rd(m_rd, $countones(s6), 3);
         a7  = legal ||
               ((y == 3'd7) && ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                                ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14))));
         if (a7) s4 = rd6 ? 4'b1000 : 4'b0111;
         else    s4 = rd6 ? T4P[y] : T4N[y];
      end
      for (int i = 0; i < 6; i++) e.code[i] = s6[5-i];
      for (int j = 0; j < 4; j++) e.code[6+j] = s4[3-j];
      m_rd   = blk_rd(rd6, $countones(s4), 2);
      e.rd   = m_rd;
      e.err  = v && k && !legal;
      e.idle = !v;
      e.rst  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         Reset        = 1'b1;
         TxValid      = 1'($urandom);
         TxParallel_8 = 8'($urandom);
         TxDataK      = 1'($urandom);
         e = '{code: 10'h17C, rd: 1'b1, err: 1'b0, idle: 1'b0, rst: 1'b1};
         m_rd = 1'b1;
         sb.push_back(e);
      end
   endtask

   task automatic send(input logic v, input logic [7:0] b, input logic k);
      exp_t e;
      @(negedge clk);
      Reset = 1'b0; TxValid = v; TxParallel_8 = b; TxDataK = k;
      model_enc(v, b, k, e);
      sb.push_back(e);
   endtask

   // Directed word: the model still advances RD, but the expectation is the fixed value given
   task automatic send_exp(input logic v, input logic [7:0] b, input logic k,
                           input logic [9:0] code, input logic rd,
                           input logic err, input logic idle);
      exp_t e;
      @(negedge clk);
      Reset = 1'b0; TxValid = v; TxParallel_8 = b; TxDataK = k;
      model_enc(v, b, k, e);
      e = '{code: code, rd: rd, err: err, idle: idle, rst: 1'b0};
      sb.push_back(e);
   endtask

   exp_t m_e;
   int   cum = 1;

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         m_e = sb.pop_front();
         checks += 4;
         if (TxParallel_10 !== m_e.code) begin
            errors++;
            $display("FAIL code got %h want %h", TxParallel_10, m_e.code);
         end
         if (RunDisp !== m_e.rd) begin
            errors++;
            $display("FAIL rundisp got %b want %b (code %h)", RunDisp, m_e.rd, m_e.code);
         end
         if (TxCodeError !== m_e.err) begin
            errors++;
            $display("FAIL codeerr got %b want %b (code %h)", TxCodeError, m_e.err, m_e.code);
         end
         if (TxIdle !== m_e.idle) begin
            errors++;
            $display("FAIL idle got %b want %b (code %h)", TxIdle, m_e.idle, m_e.code);
         end
         if (m_e.rst) begin
            cum = 1;
         end else begin
            cum += $countones(TxParallel_10) - 5;
            checks++;
            if (cum < 0 || cum > 1 || RunDisp !== cum[0]) begin
               errors++;
               $display("FAIL disparity got cum %0d rd %b want cum 0..1 matching rd", cum, RunDisp);
               cum = RunDisp ? 1 : 0;
            end
         end
      end
   end

   initial begin
      int r;
      do_reset(2);
      send_exp(1'b0, 8'h00, 1'b0, 10'h283, 1'b0, 1'b0, 1'b1);
      send_exp(1'b0, 8'h55, 1'b1, 10'h17C, 1'b1, 1'b0, 1'b1);
      send_exp(1'b0, 8'hAA, 1'b0, 10'h283, 1'b0, 1'b0, 1'b1);
      send_exp(1'b0, 8'hFF, 1'b1, 10'h17C, 1'b1, 1'b0, 1'b1);

      do_reset(1);
      send_exp(1'b1, 8'h00, 1'b0, 10'h346, 1'b1, 1'b0, 1'b0);
      send_exp(1'b1, 8'hB5, 1'b0, 10'h155, 1'b1, 1'b0, 1'b0);

      // D.17.7 from RD-: A7 form, whose +2 4b block leaves RD+
      do_reset(1);
      send_exp(1'b0, 8'h00, 1'b0, 10'h283, 1'b0, 1'b0, 1'b1);
      send_exp(1'b1, 8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0, 1'b0);

      do_reset(1);
      send_exp(1'b1, 8'h00, 1'b1, 10'h346, 1'b1, 1'b1, 1'b0);
      send_exp(1'b1, 8'hBC, 1'b1, 10'h283, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 10000; n++) begin
         if (n == 5000) begin
            do_reset(1);
            send_exp(1'b1, 8'h00, 1'b0, 10'h346, 1'b1, 1'b0, 1'b0);
         end
         r = $urandom_range(0, 99);
         if (r < 10)      send(1'b0, 8'($urandom), 1'($urandom));
         else if (r < 20) send(1'b1, LEGAL_K[$urandom_range(0, 11)], 1'b1);
         else if (r < 24) send(1'b1, 8'($urandom), 1'b1);
         else             send(1'b1, 8'($urandom), 1'b0);
      end

      @(negedge clk);
      TxValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
